step_ctrl: RTL and testbench
============================

Name: step_ctrl

Overview:
- Synthesisable clock-enable sequencer that runs the SoC free-running, or steps it for exactly N base cycles, then halts.
- Drives NUM_CH per-domain clock enables, each divided by a runtime-programmable ratio. One such domain is the 25 MHz-equivalent pixel domain.
- Sits between the debug/host command interface and the SoC enable inputs.
- Also keeps a free-running count of executed cycles.

Parameters:
NUM_CH, 2, number of clock-enable channels
DIV_W, 4, width of each channel divisor field
CNT_W, 32, width of step count and cycle counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command strobe
cmd_ready  out  1  command accept; constant 1 after reset, 0 while rst_n low
cmd_op  in  2  0=HALT, 1=RUN, 2=STEP, 3=CLEAR
cmd_count  in  CNT_W  step count, used by STEP only
div  in  NUM_CH*DIV_W  channel i divisor in bits [i*DIV_W +: DIV_W]; period = div_i+1
ce  out  NUM_CH  per-channel clock enable
busy  out  1  high in RUN or STEP
done  out  1  one-cycle pulse when a STEP completes
cycle_cnt  out  CNT_W  number of active cycles executed
state  out  2  0=IDLE, 1=RUN, 2=STEP

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; remaining, cycle_cnt and all phase counters = 0.
  - done=0, busy=0, ce=0 immediately.
  - Takes effect from any state, including mid-STEP.
- Accept rule: a command is accepted on a rising edge with cmd_valid=1. The new state is visible the next cycle (T+1).
- Active cycle: a cycle where state is RUN or STEP. busy = active.
- ce[i] = active AND (phase_i == 0). It is combinational from registers, with no extra latency.
- Per-channel divider behaviour:
  - phase_i advances only on active cycles: if phase_i >= div_i, phase_i <= 0; else phase_i <= phase_i+1.
  - div_i=0 gives ce every active cycle.
  - div_i may change at any time. If phase_i already exceeds the new div_i, it wraps to 0 on the next active cycle.
- cycle_cnt increments on every active cycle and wraps modulo 2^CNT_W.
- IDLE:
  - RUN -> RUN.
  - STEP with cmd_count=N>0 -> STEP with remaining=N.
  - STEP with N=0 -> stays IDLE; done=1 at T+1, no active cycles.
  - HALT -> no effect.
  - CLEAR -> zero cycle_cnt and all phases.
- RUN:
  - HALT -> IDLE. Phases are retained, so a later RUN resumes the divider pattern seamlessly.
  - STEP N -> STEP with remaining=N (N=0 -> IDLE plus done pulse).
  - RUN -> no effect.
  - CLEAR -> IDLE, with counters and phases zeroed.
- STEP:
  - remaining decrements on each active cycle.
  - When remaining==1 on an active cycle with no command accepted, the next state is IDLE and done=1 for exactly that next cycle.
  - Consequence: STEP N accepted at T gives active cycles T+1..T+N, IDLE and done at T+N+1.
  - HALT -> IDLE with no done pulse.
  - RUN -> RUN.
  - A new STEP reloads remaining.
  - CLEAR -> IDLE, zeroed, no done.
- Simultaneous events:
  - A command accepted in the final STEP cycle overrides natural completion, and done is not pulsed.
  - Every cycle the command is still an active cycle: counters and phases advance before the override (except CLEAR, which zeroes them).
- done is registered and pulses for one cycle only. It is otherwise 0.
- CLEAR forces phases and cycle_cnt to exactly 0 at T+1, overriding that cycle's increments.

Test Plan:
- Reset: assert rst_n=0 mid-RUN with ce[0]=1 -> ce=0, busy=0 and state=0 asynchronously. After release, cycle_cnt=0 and cmd_ready=1.
- Divided run: div={ch1=3, ch0=0}, RUN for 12 cycles then HALT -> ce[0] high all 12 cycles; ce[1] high on active cycles 1,5,9; cycle_cnt=12; IDLE one cycle after HALT.
- Exact step: STEP N=5 at T -> busy T+1..T+5, done=1 only at T+6, cycle_cnt increases by exactly 5; a second STEP N=1 gives one active cycle then done.
- Zero and override: STEP N=0 -> done at T+1 with no ce. STEP N=3, then RUN issued on the 3rd active cycle -> no done pulse, state=RUN continues.
- Phase resume and div change: div ch1=3, RUN 2 cycles, HALT, RUN -> ch1 next ce after 2 more active cycles. Mid-run div ch1 changed 3->0 while phase=2 -> phase wraps to 0, ce[1] every cycle thereafter.
- Wrap and CLEAR: CNT_W=4, RUN 18 cycles -> cycle_cnt=2. CLEAR during RUN -> state IDLE, cycle_cnt=0, phases 0, next RUN gives ce on all channels in its first cycle.

Source files
------------

// File: rtl/step_ctrl_if.sv
// Command channel between the debug/host side and the step controller.
interface step_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;

  modport master (output cmd_valid, output cmd_op, output cmd_count, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_count, output cmd_ready);
endinterface

// File: rtl/step_ctrl.sv
// Clock-enable sequencer: free-run or step the SoC for N base cycles,
// with per-channel programmable enable dividers and an active-cycle counter.
//
// state   | meaning
// IDLE(0) | no enables, counters and phases hold
// RUN(1)  | active every cycle until HALT/STEP/CLEAR
// STEP(2) | active for 'remaining' cycles, then IDLE with a done pulse
module step_ctrl #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 4,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  step_ctrl_if.slave              cmd,
  input  logic [NUM_CH*DIV_W-1:0] div,
  output logic [NUM_CH-1:0]       ce,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [1:0]              state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;

  localparam logic [1:0] OP_HALT  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  logic [1:0]                   state_q, state_d;
  logic [CNT_W-1:0]             rem_q, rem_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         done_q, done_d;
  logic [NUM_CH-1:0][DIV_W-1:0] phase_q, phase_d;
  logic                         active;
  logic                         clear;

  // The controller never back-pressures; it is ready whenever out of reset.
  assign cmd.cmd_ready = rst_n;

  assign active    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign clear     = cmd.cmd_valid && (cmd.cmd_op == OP_CLEAR);
  assign busy      = active;
  assign done      = done_q;
  assign cycle_cnt = cnt_q;
  assign state     = state_q;

  // Per-channel enables straight from the phase registers, gated by activity.
  always_comb begin
    ce = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ce[i] = active && (phase_q[i] == '0);
    end
  end

  // Phase dividers: advance on active cycles; >= also catches a divisor that
  // was lowered below the current phase, wrapping it on the next active cycle.
  always_comb begin
    phase_d = phase_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (clear) begin
        phase_d[i] = '0;
      end else if (active) begin
        if (phase_q[i] >= div[i*DIV_W +: DIV_W]) begin
          phase_d[i] = '0;
        end else begin
          phase_d[i] = phase_q[i] + DIV_W'(1);
        end
      end
    end
  end

  // Next-state: natural step completion first, then any accepted command
  // overrides it (so a command in the last step cycle suppresses done).
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    cnt_d   = active ? cnt_q + CNT_W'(1) : cnt_q;

    if (state_q == ST_STEP) begin
      rem_d = rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end

    if (cmd.cmd_valid) begin
      done_d = 1'b0;
      case (cmd.cmd_op)
        OP_HALT: state_d = ST_IDLE;
        OP_RUN:  state_d = ST_RUN;
        OP_STEP: begin
          if (cmd.cmd_count == '0) begin
            state_d = ST_IDLE;
            rem_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_STEP;
            rem_d   = cmd.cmd_count;
          end
        end
        OP_CLEAR: begin
          state_d = ST_IDLE;
          rem_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters and phases register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl: one 32-bit-counter instance for the main
// sequence and a 4-bit-counter instance for counter wrap.
module tb_step_ctrl;

  localparam logic [1:0] OP_HALT  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  logic        clk;
  logic        rst_n;
  logic [7:0]  div;
  logic [1:0]  ce;
  logic        busy, done;
  logic [31:0] cycle_cnt;
  logic [1:0]  state;

  logic [7:0]  div4;
  logic [1:0]  ce4;
  logic        busy4, done4;
  logic [3:0]  cnt4;
  logic [1:0]  state4;

  int n_checks = 0;
  int n_errors = 0;

  step_ctrl_if #(.CNT_W(32)) bus ();
  step_ctrl_if #(.CNT_W(4))  bus4 ();

  step_ctrl #(.NUM_CH(2), .DIV_W(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd(bus), .div(div), .ce(ce), .busy(busy),
    .done(done), .cycle_cnt(cycle_cnt), .state(state)
  );

  step_ctrl #(.NUM_CH(2), .DIV_W(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .cmd(bus4), .div(div4), .ce(ce4), .busy(busy4),
    .done(done4), .cycle_cnt(cnt4), .state(state4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] n);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_count = n;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic issue4(input logic [1:0] op);
    bus4.cmd_valid = 1'b1;
    bus4.cmd_op    = op;
    bus4.cmd_count = 4'd0;
    @(negedge clk);
    bus4.cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    div            = 8'h30;
    div4           = 8'h00;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = OP_HALT;
    bus.cmd_count  = '0;
    bus4.cmd_valid = 1'b0;
    bus4.cmd_op    = OP_HALT;
    bus4.cmd_count = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready_low", bus.cmd_ready, 0);
    chk("rst_ce", ce, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", bus.cmd_ready, 1);
    chk("rel_state", state, 0);
    chk("rel_cnt", cycle_cnt, 0);
    chk("rel_busy", busy, 0);

    // divided run: ch0 every cycle, ch1 every 4th active cycle
    issue(OP_RUN, 0);
    for (int k = 1; k <= 12; k++) begin
      chk("run_ce0", ce[0], 1);
      chk("run_ce1", ce[1], (k % 4 == 1));
      chk("run_busy", busy, 1);
      if (k < 12) @(negedge clk);
      else issue(OP_HALT, 0);
    end
    chk("halt_state", state, 0);
    chk("halt_busy", busy, 0);
    chk("halt_ce", ce, 0);
    chk("halt_cnt", cycle_cnt, 12);

    // exact step of 5
    issue(OP_STEP, 5);
    for (int k = 1; k <= 5; k++) begin
      chk("step5_busy", busy, 1);
      chk("step5_done", done, 0);
      chk("step5_state", state, 2);
      if (k < 5) @(negedge clk);
    end
    @(negedge clk);
    chk("step5_done_end", done, 1);
    chk("step5_idle", state, 0);
    chk("step5_cnt", cycle_cnt, 17);
    @(negedge clk);
    chk("step5_done_clr", done, 0);

    // step of 1
    issue(OP_STEP, 1);
    chk("step1_busy", busy, 1);
    chk("step1_done", done, 0);
    @(negedge clk);
    chk("step1_done_end", done, 1);
    chk("step1_busy_end", busy, 0);
    chk("step1_cnt", cycle_cnt, 18);
    @(negedge clk);
    chk("step1_done_clr", done, 0);

    // step of 0: immediate done, no activity
    issue(OP_STEP, 0);
    chk("step0_done", done, 1);
    chk("step0_state", state, 0);
    chk("step0_ce", ce, 0);
    chk("step0_cnt", cycle_cnt, 18);
    @(negedge clk);
    chk("step0_done_clr", done, 0);

    // RUN in last step cycle overrides completion
    issue(OP_STEP, 3);
    for (int k = 1; k <= 3; k++) begin
      chk("ovr_busy", busy, 1);
      if (k < 3) @(negedge clk);
      else issue(OP_RUN, 0);
    end
    chk("ovr_state", state, 1);
    chk("ovr_done", done, 0);
    chk("ovr_cnt", cycle_cnt, 21);
    @(negedge clk);
    chk("ovr_state2", state, 1);
    chk("ovr_done2", done, 0);
    issue(OP_HALT, 0);
    chk("ovr_halt", state, 0);
    chk("ovr_halt_cnt", cycle_cnt, 23);

    // phase resume across HALT
    issue(OP_CLEAR, 0);
    chk("clr_state", state, 0);
    chk("clr_cnt", cycle_cnt, 0);
    issue(OP_RUN, 0);
    chk("res_a1_ce1", ce[1], 1);
    @(negedge clk);
    chk("res_a2_ce1", ce[1], 0);
    issue(OP_HALT, 0);
    chk("res_idle_ce", ce, 0);
    @(negedge clk);
    issue(OP_RUN, 0);
    chk("res_b1_ce1", ce[1], 0);
    @(negedge clk);
    chk("res_b2_ce1", ce[1], 0);
    @(negedge clk);
    chk("res_b3_ce1", ce[1], 1);
    @(negedge clk);
    chk("res_b4_ce1", ce[1], 0);
    @(negedge clk);
    chk("res_b5_ce1", ce[1], 0);
    div = 8'h00;
    @(negedge clk);
    chk("divchg_b6_ce1", ce[1], 1);
    @(negedge clk);
    chk("divchg_b7_ce1", ce[1], 1);
    chk("divchg_cnt", cycle_cnt, 8);

    // CLEAR during RUN, then restart from zero phases
    div = 8'h32;
    issue(OP_CLEAR, 0);
    chk("clrrun_state", state, 0);
    chk("clrrun_cnt", cycle_cnt, 0);
    chk("clrrun_busy", busy, 0);
    issue(OP_RUN, 0);
    chk("restart_ce", ce, 2'b11);
    chk("restart_cnt", cycle_cnt, 0);
    @(negedge clk);
    chk("restart2_ce", ce, 2'b00);
    chk("restart2_cnt", cycle_cnt, 1);
    @(negedge clk);
    chk("restart3_ce", ce, 2'b00);
    @(negedge clk);
    chk("restart4_ce", ce, 2'b01);

    // async reset mid-run with ce[0] high
    rst_n = 1'b0;
    #1;
    chk("arst_ce", ce, 0);
    chk("arst_busy", busy, 0);
    chk("arst_state", state, 0);
    chk("arst_cnt", cycle_cnt, 0);
    chk("arst_ready", bus.cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arel_ready", bus.cmd_ready, 1);
    chk("arel_cnt", cycle_cnt, 0);
    chk("arel_state", state, 0);

    // 4-bit counter wrap over 18 active cycles
    issue4(OP_RUN);
    for (int k = 1; k <= 18; k++) begin
      if (k == 17) chk("wrap_cnt17", cnt4, 0);
      if (k < 18) @(negedge clk);
      else issue4(OP_HALT);
    end
    chk("wrap_state", state4, 0);
    chk("wrap_cnt", cnt4, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
